// File: rtl/apb_req_arbiter.sv
// -----------------------------------------------------------------------------
// apb_req_arbiter
//
// Round-robin arbiter that shares the single APB master port of apb_top among
// NREQ requesters. It latches the winning command, holds trans/re_wr/address/
// data toward apb_top until pready, then pulses done to the winner and returns
// captured read data.
//
// Optional feature macro: APB_ARB_TIMEOUT_EN
//   defined   : BUSY gives up after TIMEOUT cycles without pready and pulses err
//               together with done. rdata is left untouched on a timeout.
//   undefined : BUSY waits for pready indefinitely and err is tied low.
//
// Ports
//   pclk, preset          clock, asynchronous active-high reset
//   req, req_wr           per-requester request level and direction (1 = write)
//   req_addr, req_wdata   flattened per-requester address / write data
//                         (requester i uses slice [i*W +: W])
//   gnt                   one-hot grant, high from latch through completion
//   done                  one-cycle completion pulse to the winner
//   err                   one-cycle timeout pulse, coincident with done
//   rdata                 captured read data, held until the next read completes
//   trans, re_wr          command strobe and direction toward apb_top
//   wr_paddr, re_paddr    latched address (both carry the same value)
//   wr_data               latched write data
//   pready, pdata         completion and read data from apb_top
// -----------------------------------------------------------------------------
module apb_req_arbiter #(
   parameter int NREQ    = 4,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic                   pclk,
   input  logic                   preset,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ-1:0]        req_wr,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   input  logic [NREQ*DATA_W-1:0] req_wdata,
   output logic [NREQ-1:0]        gnt,
   output logic [NREQ-1:0]        done,
   output logic                   err,
   output logic [DATA_W-1:0]      rdata,
   output logic                   trans,
   output logic                   re_wr,
   output logic [ADDR_W-1:0]      wr_paddr,
   output logic [ADDR_W-1:0]      re_paddr,
   output logic [DATA_W-1:0]      wr_data,
   input  logic                   pready,
   input  logic [DATA_W-1:0]      pdata
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state_reg, state_next;
   logic [IDX_W-1:0]   last_reg, last_next;
   logic [IDX_W-1:0]   win_reg, win_next;
   logic [IDX_W-1:0]   pick, idx;
   logic               pick_valid;

   logic [NREQ-1:0]    gnt_next, done_next;
   logic               trans_next, re_wr_next;
   logic [ADDR_W-1:0]  addr_next;
   logic [DATA_W-1:0]  wr_data_next, rdata_next;

   logic [ADDR_W-1:0]  addr_arr  [NREQ];
   logic [DATA_W-1:0]  wdata_arr [NREQ];

   // Unpack the flattened command buses into per-requester arrays.
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
         assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
      end
   endgenerate

`ifdef APB_ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             err_next;
`else
   logic unused_cfg;
   assign unused_cfg = (TIMEOUT > 0);
   assign err        = 1'b0;
`endif

   // Round-robin pick: walk offsets from NREQ down to 1 so the lowest offset
   // after last_reg (the highest-priority candidate) is the final assignment.
   always_comb begin
      pick       = '0;
      pick_valid = 1'b0;
      idx        = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = IDX_W'((int'(last_reg) + k) % NREQ);
         if (req[idx]) begin
            pick       = idx;
            pick_valid = 1'b1;
         end
      end
   end

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_next   = state_reg;
      last_next    = last_reg;
      win_next     = win_reg;
      gnt_next     = gnt;
      done_next    = '0;
      trans_next   = trans;
      re_wr_next   = re_wr;
      addr_next    = wr_paddr;
      wr_data_next = wr_data;
      rdata_next   = rdata;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_next     = cnt_reg;
      err_next     = 1'b0;
`endif
      case (state_reg)
         IDLE: begin
            if (pick_valid) begin
               win_next     = pick;
               gnt_next     = NREQ'(1) << pick;
               trans_next   = 1'b1;
               re_wr_next   = req_wr[pick];
               addr_next    = addr_arr[pick];
               wr_data_next = wdata_arr[pick];
               state_next   = BUSY;
`ifdef APB_ARB_TIMEOUT_EN
               cnt_next     = '0;
`endif
            end else begin
               trans_next = 1'b0;
            end
         end
         BUSY: begin
            // pready has priority over an expiring timeout in the same cycle.
            if (pready) begin
               if (!re_wr) begin
                  rdata_next = pdata;
               end
               trans_next = 1'b0;
               done_next  = gnt;
               state_next = DONE;
            end
`ifdef APB_ARB_TIMEOUT_EN
            else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
               trans_next = 1'b0;
               done_next  = gnt;
               err_next   = 1'b1;
               state_next = DONE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
`endif
         end
         DONE: begin
            gnt_next   = '0;
            last_next  = win_reg;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_reg <= IDLE;
         last_reg  <= IDX_W'(NREQ - 1);
         win_reg   <= '0;
         gnt       <= '0;
         done      <= '0;
         trans     <= 1'b0;
         re_wr     <= 1'b0;
         wr_paddr  <= '0;
         re_paddr  <= '0;
         wr_data   <= '0;
         rdata     <= '0;
`ifdef APB_ARB_TIMEOUT_EN
         cnt_reg   <= '0;
         err       <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         last_reg  <= last_next;
         win_reg   <= win_next;
         gnt       <= gnt_next;
         done      <= done_next;
         trans     <= trans_next;
         re_wr     <= re_wr_next;
         wr_paddr  <= addr_next;
         re_paddr  <= addr_next;
         wr_data   <= wr_data_next;
         rdata     <= rdata_next;
`ifdef APB_ARB_TIMEOUT_EN
         cnt_reg   <= cnt_next;
         err       <= err_next;
`endif
      end
   end

endmodule
